// File: rtl/bin4_bcd_driver_pkg.sv
// Shared constants and state encoding for the binary-to-BCD display driver.
package bin4_bcd_driver_pkg;

   localparam int unsigned BCD_MAX        = 9999;
   localparam int unsigned BCD_DIGITS     = 4;
   localparam int unsigned DIGIT_W        = 4;
   localparam int unsigned SCRATCH_DIGITS = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/bin4_bcd_driver_bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
   import bin4_bcd_driver_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= DIGIT_W'(5)) begin
         digit_o = digit_i + DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/bin4_bcd_driver.sv
// Sequential shift-and-add-3 converter; digit outputs change only on the done edge.
module bin4_bcd_driver
   import bin4_bcd_driver_pkg::*;
#(
   parameter int unsigned BIN_W    = 14,
   parameter bit          SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIN_W-1:0] bin,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       a0,
   output logic [3:0]       a1,
   output logic [3:0]       a2,
   output logic [3:0]       a3
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam int unsigned SCR_W = SCRATCH_DIGITS * DIGIT_W;
   localparam int unsigned OUT_W = BCD_DIGITS * DIGIT_W;

   localparam logic [BIN_W-1:0] MAX_BIN    = BIN_W'(BCD_MAX);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BIN_W - 1);
   localparam logic [OUT_W-1:0] SAT_DIGITS = {BCD_DIGITS{DIGIT_W'(9)}};

   state_e           state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [SCR_W-1:0] scr_q, scr_d, scr_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic [OUT_W-1:0] dig_q, dig_d;

   for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
         .digit_o (scr_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         scr_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         dig_q      <= '0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         scr_q      <= scr_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         dig_q      <= dig_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      scr_d      = scr_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      dig_d      = dig_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d      = bin;
               scr_d      = '0;
               cnt_d      = '0;
               ovf_pend_d = (bin > MAX_BIN);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            {scr_d, bin_d} = {scr_adj, bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
            // Final shift: publish the freshly shifted scratch, not the registered one.
            if (cnt_q == LAST_CNT) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ovf_d   = ovf_pend_q;
               dig_d   = (ovf_pend_q && SATURATE) ? SAT_DIGITS : scr_d[OUT_W-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == SHIFT);
   assign done = done_q;
   assign ovf  = ovf_q;
   assign a0   = dig_q[0*DIGIT_W +: DIGIT_W];
   assign a1   = dig_q[1*DIGIT_W +: DIGIT_W];
   assign a2   = dig_q[2*DIGIT_W +: DIGIT_W];
   assign a3   = dig_q[3*DIGIT_W +: DIGIT_W];

endmodule

// File: doc/bin4_bcd_driver.md
Name: bin4_bcd_driver

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3) that produces the four BCD digit inputs consumed by the pixel-level digit/'s' renderer.
- Accepts a binary count, for example elapsed seconds from the game timer, through a start/done handshake.
- Outputs the units-to-thousands digits a0..a3 as registers.
- The digit outputs update atomically, so the renderer never displays a partially converted value mid-frame.

Parameters:
- BIN_W, 14: width of the binary input. Legal range is 14..16. The conversion takes BIN_W shift cycles.
- SATURATE, 1: when 1, inputs above 9999 display as 9999 and ovf is set. When 0, the output shows the value modulo 10000 and ovf is still set.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- bin  in  BIN_W  binary value to convert; sampled only on the accepting edge.
- start  in  1  conversion request; level-sampled.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when a0..a3 and ovf have been updated.
- ovf  out  1  last accepted bin was greater than 9999.
- a0  out  4  units digit, BCD.
- a1  out  4  tens digit, BCD.
- a2  out  4  hundreds digit, BCD.
- a3  out  4  thousands digit, BCD.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = 0; done = 0; ovf = 0; a0..a3 = 0; shift and scratch registers cleared.
- States: IDLE, SHIFT.
- IDLE, with start = 1 at edge E:
  - Capture bin into the shift register and clear the 20-bit BCD scratch (five digits; the fifth is needed for values up to 65535).
  - Latch ovf_pend = (bin > 9999). Clear the counter. Go to SHIFT. busy = 1.
- SHIFT, each edge E+1..E+BIN_W:
  - Add 3 to every scratch digit that is >= 5.
  - Shift {scratch, binreg} left by one. Increment the counter.
- Completion, edge E+BIN_W:
  - Load a0..a3 from the final scratch digits; or load 9,9,9,9 if ovf_pend and SATURATE = 1.
  - Load ovf = ovf_pend. Pulse done = 1 for one cycle. busy = 0. Return to IDLE.
- Timing: busy is high for exactly BIN_W cycles. done rises BIN_W cycles after the accepting edge.
- start while busy: ignored. No queuing, and the conversion in flight is unaffected.
- start during the done cycle: accepted, because the block is already in IDLE. Back-to-back throughput is one conversion per BIN_W+1 cycles.
- bin changing after the accepting edge: no effect on the current conversion.
- Outputs a0..a3 and ovf hold their values between completions. The intermediate scratch value is never visible on the ports.
- Each digit output is always in 0..9.
- rst_n asserted mid-conversion: the conversion is aborted, the outputs return to their reset values, and done does not pulse.
- start held high continuously: the block converts repeatedly, re-sampling bin at each IDLE edge.

Decomposition:
- Shared package holds:
  - BCD_MAX = 9999
  - BCD_DIGITS = 4
  - state encoding: IDLE = 1'b0, SHIFT = 1'b1
  - digit width = 4
- Sub-module bcd_add3: combinational 4-bit cell, output = in + 3 if in >= 5, else in. Instantiated five times on the scratch digits.
- Counter width: $clog2(BIN_W+1).

Test Plan:
- Reset, then bin = 1234 with a one-cycle start → busy high for 14 cycles; done pulse; a3 = 1, a2 = 2, a1 = 3, a0 = 4; ovf = 0.
- bin = 0, then bin = 9999, each run as a separate conversion → 0,0,0,0 then 9,9,9,9; ovf = 0 both times; done pulses once per run.
- bin = 12000 with SATURATE = 1 → 9,9,9,9 and ovf = 1. Same input with SATURATE = 0 → 2,0,0,0 and ovf = 1. A following conversion of bin = 5 clears ovf.
- Convert 4321, pulse start again at cycles 3 and 10 with bin = 7 → exactly one done pulse; result 4,3,2,1. A start in the done cycle with bin = 7 → second result 0,0,0,7 after 14 more cycles.
- Convert 8888 to completion, then start bin = 5555 and drop rst_n at cycle 6 → outputs 0 immediately; busy = 0; no done pulse. After release, a fresh conversion of 42 → 0,0,4,2.
